// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Steps through NCH waveform ROM channels, each with its own runtime last
//   address, and drives a single registered sample bus plus a framing
//   trigger. The sequencer advances only on sysclk edges with tick=1.
//
// Ports
//   sysclk      in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   tick        in   sample strobe
//   run         in   1 = sequence, 0 = idle
//   mode        in   0 manual, 1 auto-cycle, 2 one-shot, 3 manual
//   sel         in   channel for manual mode and at start (>= NCH means 0)
//   ch_en       in   per-channel output gate (disabled channel plays zeros)
//   latch_en    in   channels eligible for auto / one-shot advance
//   ch_len      in   last address per channel, channel i at [i*AW+:AW]
//   rom_data    in   combinational ROM words, channel i at [i*DW+:DW]
//   rom_addr    out  shared ROM address
//   cur_ch      out  channel currently playing
//   data_out    out  registered sample
//   data_valid  out  one-cycle pulse when data_out updates
//   frame_cnt   out  frame position 0..FRAME-1
//   frame_trig  out  one-cycle pulse when frame_cnt is loaded with TRIG_PHASE
//   seq_done    out  one-cycle pulse at one-shot completion
//   busy        out  high while in RUN
module wave_sequencer #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int FRAME      = 13,
  parameter int TRIG_PHASE = 1,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int FW        = (FRAME > 1) ? $clog2(FRAME) : 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              tick,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     sel,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    latch_en,
  input  logic [NCH*AW-1:0] ch_len,
  input  logic [NCH*DW-1:0] rom_data,
  output logic [AW-1:0]     rom_addr,
  output logic [CW-1:0]     cur_ch,
  output logic [DW-1:0]     data_out,
  output logic              data_valid,
  output logic [FW-1:0]     frame_cnt,
  output logic              frame_trig,
  output logic              seq_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);
  localparam logic [FW-1:0] TRIG_VAL   = FW'(TRIG_PHASE);

  state_t        state_r;
  state_t        state_nxt_s;

  logic [AW-1:0] rom_addr_r;
  logic [CW-1:0] cur_ch_r;
  logic [DW-1:0] data_out_r;
  logic [FW-1:0] frame_cnt_r;
  logic          data_valid_r;
  logic          frame_trig_r;
  logic          seq_done_r;
  logic          busy_r;

  logic [DW-1:0] rom_word_s [NCH];
  logic [AW-1:0] len_word_s [NCH];
  logic [CW-1:0] sel_eff_s;
  logic          at_bound_s;
  logic [DW-1:0] sample_s;
  logic [FW-1:0] frame_nxt_s;
  logic [CW:0]   auto_hit_s;
  logic [CW:0]   above_hit_s;
  logic [CW-1:0] next_ch_s;
  logic          finish_s;

  // Round-robin search: first channel after cur (wrapping, cur excluded)
  // with its mask bit set. Returns {found, index}. Scanning from the far end
  // lets the nearest candidate overwrite the result last.
  function automatic logic [CW:0] find_auto(input logic [CW-1:0] cur,
                                            input logic [NCH-1:0] mask);
    logic [CW:0]   res;
    logic [CW-1:0] idx_l;
    res = {(CW+1){1'b0}};
    for (int k = NCH - 1; k >= 1; k--) begin
      idx_l = CW'((32'(cur) + 32'(k)) % 32'(NCH));
      if (mask[idx_l]) begin
        res = {1'b1, idx_l};
      end
    end
    return res;
  endfunction

  // Ascending search: first channel strictly above cur with its mask bit set.
  function automatic logic [CW:0] find_above(input logic [CW-1:0] cur,
                                             input logic [NCH-1:0] mask);
    logic [CW:0] res;
    res = {(CW+1){1'b0}};
    for (int k = NCH - 1; k >= 0; k--) begin
      if ((32'(k) > 32'(cur)) && mask[CW'(k)]) begin
        res = {1'b1, CW'(k)};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign rom_word_s[g] = rom_data[g*DW +: DW];
    assign len_word_s[g] = ch_len[g*AW +: AW];
  end

  assign sel_eff_s   = (32'(sel) < 32'(NCH)) ? sel : {CW{1'b0}};
  // ch_len is read live, so a length shrunk below rom_addr only matches
  // again after the address wraps modulo 2^AW.
  assign at_bound_s  = (rom_addr_r == len_word_s[cur_ch_r]);
  assign sample_s    = ch_en[cur_ch_r] ? rom_word_s[cur_ch_r] : {DW{1'b0}};
  assign frame_nxt_s = (frame_cnt_r == FRAME_LAST) ? {FW{1'b0}} : frame_cnt_r + FW'(1);
  assign auto_hit_s  = find_auto(cur_ch_r, latch_en);
  assign above_hit_s = find_above(cur_ch_r, latch_en);

  // Channel selected at a boundary; finish_s flags a one-shot boundary with
  // no further eligible channel.
  always_comb begin
    next_ch_s = cur_ch_r;
    finish_s  = 1'b0;
    case (mode)
      2'd1: begin
        if (auto_hit_s[CW]) begin
          next_ch_s = auto_hit_s[CW-1:0];
        end else begin
          next_ch_s = cur_ch_r;
        end
      end
      2'd2: begin
        if (above_hit_s[CW]) begin
          next_ch_s = above_hit_s[CW-1:0];
        end else begin
          next_ch_s = cur_ch_r;
          finish_s  = at_bound_s;
        end
      end
      default: next_ch_s = sel_eff_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else if (tick && finish_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address, channel, sample, frame and pulse registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rom_addr_r   <= {AW{1'b0}};
      cur_ch_r     <= {CW{1'b0}};
      data_out_r   <= {DW{1'b0}};
      frame_cnt_r  <= {FW{1'b0}};
      data_valid_r <= 1'b0;
      frame_trig_r <= 1'b0;
      seq_done_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r       <= (state_nxt_s == ST_RUN);
      data_valid_r <= 1'b0;
      frame_trig_r <= 1'b0;
      seq_done_r   <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (!run) begin
            // Leaving for IDLE; any in-flight sample is dropped.
            rom_addr_r  <= {AW{1'b0}};
            cur_ch_r    <= sel_eff_s;
            data_out_r  <= {DW{1'b0}};
            frame_cnt_r <= {FW{1'b0}};
          end else if (tick && finish_s) begin
            rom_addr_r  <= {AW{1'b0}};
            cur_ch_r    <= {CW{1'b0}};
            data_out_r  <= {DW{1'b0}};
            frame_cnt_r <= {FW{1'b0}};
            seq_done_r  <= 1'b1;
          end else if (tick) begin
            data_out_r   <= sample_s;
            data_valid_r <= 1'b1;
            frame_cnt_r  <= frame_nxt_s;
            frame_trig_r <= (frame_nxt_s == TRIG_VAL);
            if (at_bound_s) begin
              rom_addr_r <= {AW{1'b0}};
              cur_ch_r   <= next_ch_s;
            end else begin
              rom_addr_r <= rom_addr_r + AW'(1);
            end
          end else begin
            // No strobe: everything holds.
          end
        end
        ST_DONE: begin
          rom_addr_r  <= {AW{1'b0}};
          cur_ch_r    <= {CW{1'b0}};
          data_out_r  <= {DW{1'b0}};
          frame_cnt_r <= {FW{1'b0}};
        end
        default: begin
          // IDLE: parked at address 0 with sel preloaded; a tick on the
          // entry edge into RUN is deliberately ignored.
          rom_addr_r  <= {AW{1'b0}};
          cur_ch_r    <= sel_eff_s;
          data_out_r  <= {DW{1'b0}};
          frame_cnt_r <= {FW{1'b0}};
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_r;
  assign cur_ch     = cur_ch_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_cnt  = frame_cnt_r;
  assign frame_trig = frame_trig_r;
  assign seq_done   = seq_done_r;
  assign busy       = busy_r;

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Parametrised successor to the four-ROM waveform splitter.
- Steps through NCH waveform ROM channels, each with its own runtime length, and drives one sample bus plus a framing trigger for the DAC/serialiser path.
- Adds manual, auto-cycle and one-shot modes, per-channel enable/latch masks, and a single clock with a sample strobe in place of two clocks.

Parameters:
NCH, 4, number of waveform channels (2..16)
DW, 8, sample width
AW, 8, ROM address / length width
FRAME, 13, frame counter modulus (counts 0..FRAME-1)
TRIG_PHASE, 1, frame_cnt value at which frame_trig fires (< FRAME)

Ports:
sysclk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
tick  in  1  sample strobe; the sequencer advances only on sysclk edges with tick=1
run  in  1  1 = sequence, 0 = idle
mode  in  2  0 manual, 1 auto-cycle, 2 one-shot, 3 reserved (treated as manual)
sel  in  clog2(NCH)  channel used in manual mode and at start
ch_en  in  NCH  output gate per channel; a disabled channel plays zeros
latch_en  in  NCH  channels eligible for auto/one-shot advance
ch_len  in  NCH*AW  last address per channel, channel i at [i*AW+:AW]
rom_data  in  NCH*DW  combinational ROM outputs, channel i at [i*DW+:DW]
rom_addr  out  AW  shared ROM address
cur_ch  out  clog2(NCH)  channel currently playing
data_out  out  DW  registered sample
data_valid  out  1  1-cycle pulse when data_out updates
frame_cnt  out  clog2(FRAME)  frame position
frame_trig  out  1  1-cycle pulse
seq_done  out  1  1-cycle pulse at one-shot completion
busy  out  1  high in RUN state

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rom_addr=0, cur_ch=0, data_out=0, frame_cnt=0; data_valid, frame_trig, seq_done, busy all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - rom_addr=0, frame_cnt=0, data_out=0, cur_ch=sel every cycle.
  - run=1 moves to RUN on the next edge, independent of tick.
- RUN, on each tick:
  - data_out <= rom_data[cur_ch] at the current rom_addr if ch_en[cur_ch]=1, else 0.
  - data_valid=1 on the following cycle.
  - Latency: address to data_out is 1 sysclk edge.
  - frame_cnt wraps FRAME-1 -> 0.
  - frame_trig pulses for exactly one sysclk on the tick that loads frame_cnt=TRIG_PHASE.
- Address: if rom_addr == ch_len[cur_ch], rom_addr <= 0 (channel boundary); otherwise rom_addr+1. ch_len=0 gives a one-sample channel.
- At a channel boundary, the next channel depends on mode and latch_en, both sampled at the boundary:
  - Manual: cur_ch <= sel.
  - Auto: cur_ch <= first index after cur_ch, searched round-robin ascending, with latch_en set. If none is set (other than cur_ch), cur_ch is unchanged.
  - One-shot: cur_ch <= first index above cur_ch with latch_en set. If none exists, assert seq_done for one cycle, go to DONE, set rom_addr=0 and data_out=0.
- Changes to sel, mode or ch_len mid-channel have no effect until the next boundary comparison. ch_len is read live for the compare, so a length reduced below the current rom_addr wraps at AW overflow.
- DONE: outputs held at 0, busy=0. run=0 returns to IDLE; run=1 stays in DONE.
- run=0 in RUN: go to IDLE on the next sysclk edge regardless of tick; an in-flight sample is discarded.
- Reset asserted mid-operation clears everything immediately.
- tick=0: all registers hold; frame_trig, data_valid and seq_done stay 0.
- tick on the same edge as entering RUN: ignored; the first sample is on the next tick.
- sel >= NCH: treated as 0.
- Widths: counters wrap modulo 2^AW internally; no saturation.

Test Plan:
1. NCH=4, mode=0, sel=2, ch_len[2]=3, tick every cycle, run=1 -> rom_addr 0,1,2,3,0,...; data_out follows rom_data[2] one cycle later; cur_ch stays 2.
2. mode=1, latch_en=4'b1011, start sel=0, lengths 155/142/116/77 -> channel order 0,1,3,0,...; each channel boundary occurs after len+1 ticks; channel 2 is never played.
3. mode=2, latch_en=4'b0110, sel=1 -> plays channels 1 then 2; seq_done pulses once at channel 2's last address; state DONE with data_out=0; run=0 -> IDLE.
4. FRAME=13, TRIG_PHASE=1, tick every 3rd cycle -> frame_trig is a single sysclk pulse every 13 ticks (39 cycles); no pulse when tick=0.
5. ch_en[1]=0 in auto mode -> channel 1 timing is preserved but data_out=0 throughout it.
6. Assert reset low mid-channel with rom_addr=50 -> all outputs 0 immediately. Toggle run low mid-run -> IDLE on the next edge, rom_addr=0, frame_cnt=0.
